// File: rtl/serial_adsub_engine_if.sv
// serial_adsub_engine_if: operand request and result bus for the bit-serial adder/subtractor
interface serial_adsub_engine_if #(parameter int WIDTH = 8);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  modport master (output start, mode, op_a, op_b, input busy, done, result, cout, ovf);
  modport slave  (input start, mode, op_a, op_b, output busy, done, result, cout, ovf);
endinterface

// File: rtl/serial_adsub_engine.sv
// serial_adsub_engine: WIDTH-bit add/subtract computed LSB-first through one full adder/subtractor cell
module serial_adsub_engine #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_adsub_engine_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d, c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             s, c_n, last;
  always_comb begin
    s       = a_q[0] ^ b_q[0] ^ c_q;
    c_n     = mode_q ? (~a_q[0] & b_q[0] | ~(a_q[0] ^ b_q[0]) & c_q)
                     : (a_q[0] & b_q[0] | b_q[0] & c_q | a_q[0] & c_q);
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        a_d     = bus.op_a;
        b_d     = bus.op_b;
        mode_d  = bus.mode;
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
    end else if (state_q == SHIFT) begin
      res_d = {s, res_q[WIDTH-1:1]};
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = c_n;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        // overflow: carry/borrow into the sign bit differs from the one leaving it
        cout_d  = c_n;
        ovf_d   = c_q ^ c_n;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.busy   = state_q == SHIFT;
  assign bus.done   = state_q == DONE;
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_adsub_engine.sv
// tb_serial_adsub_engine: directed table, corner sequences and random ops against an arithmetic model
module tb_serial_adsub_engine;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0, bad = 0, cyc = 0, last_done = 0;
  logic pc = 1'b0, po = 1'b0;
  serial_adsub_engine_if #(.WIDTH(W)) bus ();
  serial_adsub_engine #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [W-1:0] a, b;
    logic         m;
    logic [W-1:0] r;
    logic         co, ov;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic m);
    logic [W:0] t;
    logic       ov;
    t  = m ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    ov = (m ? (a[W-1] != b[W-1]) : (a[W-1] == b[W-1])) && (t[W-1] != a[W-1]);
    return {ov, t};
  endfunction
  task automatic run_op(input logic [W-1:0] a, b, input logic m,
                        input logic [W-1:0] er, input logic eco, eov);
    int   lat, busy_n;
    logic hold_ok;
    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.mode = m;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op_a = W'($urandom); bus.op_b = W'($urandom); bus.mode = ~m;
    lat = 0; busy_n = 0; hold_ok = 1'b1;
    while (!bus.done && lat < 3 * W) begin
      if (bus.busy) busy_n++;
      if (bus.cout !== pc || bus.ovf !== po) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.done) last_done = cyc;
    chk("latency", lat, W);
    chk("busy_cycles", busy_n, W);
    chk("hold_during_shift", hold_ok, 1);
    chk("result", bus.result, er);
    chk("cout", bus.cout, eco);
    chk("ovf", bus.ovf, eov);
    pc = eco; po = eov;
    @(posedge clk); #1;
    chk("done_single_pulse", {bus.done, bus.busy}, 0);
    chk("result_held", bus.result, er);
  endtask
  task automatic run_rand(input logic m);
    logic [W-1:0] a, b;
    logic [W+1:0] e;
    a = W'($urandom); b = W'($urandom);
    e = model(a, b, m);
    run_op(a, b, m, e[W-1:0], e[W], e[W+1]);
  endtask
  initial begin
    int prev, dn;
    tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0};
    bus.start = 1'b0; bus.mode = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.cout, bus.ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {bus.busy, bus.done}, 0);
    for (int i = 0; i < 6; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].r, tbl[i].co, tbl[i].ov);
    // start pulses during SHIFT and DONE must be ignored
    bus.start = 1'b1; bus.op_a = 8'h05; bus.op_b = 8'h03; bus.mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1; bus.op_a = 8'hAA; bus.mode = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dn = 0;
    for (int k = 0; k < 3 * W && dn == 0; k++) begin
      if (bus.done) dn++;
      else begin @(posedge clk); #1; end
    end
    chk("ignore_done_seen", dn, 1);
    chk("ignore_result", bus.result, 8'h08);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done || bus.busy) dn++;
      chk("ignore_hold", bus.result, 8'h08);
      @(posedge clk); #1;
    end
    chk("ignore_no_extra_op", dn, 0);
    pc = 1'b0; po = 1'b0;
    // reset in the middle of an operation
    bus.start = 1'b1; bus.op_a = 8'h7F; bus.op_b = 8'h7F; bus.mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midreset_outputs", {bus.busy, bus.done, bus.result, bus.cout, bus.ovf}, 0);
    dn = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.done) dn++; end
    chk("midreset_no_done", dn, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    // back-to-back: start on the first idle cycle after each done
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      run_rand(i >= 3);
      if (i > 0) chk("b2b_spacing", last_done - prev, W + 2);
      prev = last_done;
    end
    for (int i = 0; i < 20; i++) run_rand(1'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
